// File: rtl/game_pkg.sv
// Shared whack-a-mole types: game state encoding, BCD digit type and the blank code
// understood by the seven-segment driver.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } game_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BLANK_DIGIT  = 4'hF;
   localparam int         SCORE_DIGITS = 4;
   localparam int         TIMER_DIGITS = 2;

   function automatic bcd_digit_t bcd_tens(input int value);
      return bcd_digit_t'((value / 10) % 10);
   endfunction

   function automatic bcd_digit_t bcd_units(input int value);
      return bcd_digit_t'(value % 10);
   endfunction

endpackage

// File: rtl/game_scoreboard_if.sv
// Control pulses into the scoreboard and the eight display digits out to the driver.
interface game_scoreboard_if;
   import game_pkg::*;

   logic       start;
   logic       hit;
   logic       miss;
   logic       running;
   logic       game_over;
   bcd_digit_t display7;
   bcd_digit_t display6;
   bcd_digit_t display5;
   bcd_digit_t display4;
   bcd_digit_t display3;
   bcd_digit_t display2;
   bcd_digit_t display1;
   bcd_digit_t display0;

   modport master (
      output start, hit, miss,
      input  running, game_over,
      input  display7, display6, display5, display4,
      input  display3, display2, display1, display0
   );

   modport slave (
      input  start, hit, miss,
      output running, game_over,
      output display7, display6, display5, display4,
      output display3, display2, display1, display0
   );

endinterface

// File: rtl/bcd_digit.sv
// One cascadable decimal digit. carry/borrow flag that this digit wraps on the current
// inc/dec, so they feed the next digit's inc/dec directly.
module bcd_digit
   import game_pkg::*;
#(
   parameter bcd_digit_t RESET_VALUE = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_n,
   input  logic       load_n,
   input  bcd_digit_t load_value,
   input  logic       inc,
   input  logic       dec,
   output bcd_digit_t value,
   output logic       carry,
   output logic       borrow
);

   bcd_digit_t value_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_reg <= RESET_VALUE;
      end else if (!clr_n) begin
         value_reg <= 4'd0;
      end else if (!load_n) begin
         value_reg <= load_value;
      end else if (inc && !dec) begin
         value_reg <= (value_reg == 4'd9) ? 4'd0 : value_reg + 4'd1;
      end else if (dec && !inc) begin
         value_reg <= (value_reg == 4'd0) ? 4'd9 : value_reg - 4'd1;
      end
   end

   assign value  = value_reg;
   assign carry  = inc && !dec && (value_reg == 4'd9);
   assign borrow = dec && !inc && (value_reg == 4'd0);

endmodule

// File: rtl/game_scoreboard.sv
// Whack-a-mole score and countdown engine: IDLE/RUN/OVER state machine, 4-digit BCD
// score, 2-digit BCD seconds timer and the eight digits for the seven-segment driver.
module game_scoreboard
   import game_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int GAME_SECONDS = 60
) (
   input  logic              clk,
   input  logic              rst_n,
   game_scoreboard_if.slave  bus
);

   if (GAME_SECONDS < 1 || GAME_SECONDS > 99) begin : g_bad_game_seconds
      $error("game_scoreboard: GAME_SECONDS must be within 1..99");
   end
   if (CLK_HZ < 2) begin : g_bad_clk_hz
      $error("game_scoreboard: CLK_HZ must be at least 2");
   end

   localparam int                    PRESCALE_W    = $clog2(CLK_HZ);
   localparam logic [PRESCALE_W-1:0] TICK_COUNT    = PRESCALE_W'(CLK_HZ - 1);
   localparam bcd_digit_t            SECONDS_TENS  = bcd_tens(GAME_SECONDS);
   localparam bcd_digit_t            SECONDS_UNITS = bcd_units(GAME_SECONDS);

   game_state_t             state_reg;
   logic                    running_reg;
   logic                    game_over_reg;
   logic [PRESCALE_W-1:0]   prescale_reg;

   bcd_digit_t score_digit [SCORE_DIGITS];
   bcd_digit_t timer_digit [TIMER_DIGITS];

   logic in_run;
   logic start_accept;
   logic tick;
   logic final_tick;
   logic score_max;
   logic score_zero;
   logic score_inc;
   logic score_dec;

   assign in_run       = (state_reg == RUN);
   assign start_accept = bus.start && !in_run;
   assign tick         = in_run && (prescale_reg == TICK_COUNT);
   assign final_tick   = tick && (timer_digit[1] == 4'd0) && (timer_digit[0] == 4'd1);

   always_comb begin
      score_max  = 1'b1;
      score_zero = 1'b1;
      for (int i = 0; i < SCORE_DIGITS; i++) begin
         score_max  = score_max && (score_digit[i] == 4'd9);
         score_zero = score_zero && (score_digit[i] == 4'd0);
      end
   end

   // Saturation is resolved here so the digit cascade never wraps past 9999 or 0000.
   assign score_inc = in_run && bus.hit && !bus.miss && !score_max;
   assign score_dec = in_run && bus.miss && !bus.hit && !score_zero;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         running_reg   <= 1'b0;
         game_over_reg <= 1'b0;
         prescale_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE, OVER: begin
               if (bus.start) begin
                  state_reg     <= RUN;
                  running_reg   <= 1'b1;
                  game_over_reg <= 1'b0;
                  prescale_reg  <= '0;
               end
            end
            RUN: begin
               prescale_reg <= tick ? '0 : prescale_reg + PRESCALE_W'(1);
               if (final_tick) begin
                  state_reg     <= OVER;
                  running_reg   <= 1'b0;
                  game_over_reg <= 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               running_reg   <= 1'b0;
               game_over_reg <= 1'b0;
            end
         endcase
      end
   end

   genvar gi;

   for (gi = 0; gi < SCORE_DIGITS; gi++) begin : g_score
      logic inc;
      logic dec;
      logic carry;
      logic borrow;

      if (gi == 0) begin : g_lsd
         assign inc = score_inc;
         assign dec = score_dec;
      end else begin : g_chain
         assign inc = g_score[gi-1].carry;
         assign dec = g_score[gi-1].borrow;
      end

      bcd_digit #(
         .RESET_VALUE (4'd0)
      ) u_digit (
         .clk        (clk),
         .rst_n      (rst_n),
         .clr_n      (!start_accept),
         .load_n     (1'b1),
         .load_value (4'd0),
         .inc        (inc),
         .dec        (dec),
         .value      (score_digit[gi]),
         .carry      (carry),
         .borrow     (borrow)
      );
   end

   // The timer only counts down and leaves RUN at 00, so its borrow chain never wraps.
   for (gi = 0; gi < TIMER_DIGITS; gi++) begin : g_timer
      localparam bcd_digit_t SEED = (gi == 0) ? SECONDS_UNITS : SECONDS_TENS;
      logic dec;
      logic carry;
      logic borrow;

      if (gi == 0) begin : g_lsd
         assign dec = tick;
      end else begin : g_chain
         assign dec = g_timer[gi-1].borrow;
      end

      bcd_digit #(
         .RESET_VALUE (SEED)
      ) u_digit (
         .clk        (clk),
         .rst_n      (rst_n),
         .clr_n      (1'b1),
         .load_n     (!start_accept),
         .load_value (SEED),
         .inc        (1'b0),
         .dec        (dec),
         .value      (timer_digit[gi]),
         .carry      (carry),
         .borrow     (borrow)
      );
   end

   logic unused_chain;
   assign unused_chain = ^{g_score[SCORE_DIGITS-1].carry, g_score[SCORE_DIGITS-1].borrow,
                           g_timer[TIMER_DIGITS-1].borrow, g_timer[0].carry, g_timer[1].carry};

   assign bus.running   = running_reg;
   assign bus.game_over = game_over_reg;
   assign bus.display7  = score_digit[3];
   assign bus.display6  = score_digit[2];
   assign bus.display5  = score_digit[1];
   assign bus.display4  = score_digit[0];
   assign bus.display3  = BLANK_DIGIT;
   assign bus.display2  = BLANK_DIGIT;
   assign bus.display1  = timer_digit[1];
   assign bus.display0  = timer_digit[0];

endmodule

// File: tb/tb_game_scoreboard.sv
// Scoreboard bench: stimulus queues expected digit/flag snapshots with a due cycle, a
// monitor compares them against the DUT on the falling edge after that cycle's edge.
module tb_game_scoreboard;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   bit   done  = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   game_scoreboard_if a_if ();
   game_scoreboard_if b_if ();

   game_scoreboard #(
      .CLK_HZ       (4),
      .GAME_SECONDS (3)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if)
   );

   game_scoreboard #(
      .CLK_HZ       (100_000),
      .GAME_SECONDS (99)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if)
   );

   typedef struct {
      string       name;
      int          due;
      bit          sel;
      logic [15:0] score;
      logic [7:0]  timer;
      logic        run;
      logic        over;
   } exp_t;

   exp_t exp_q [$];
   exp_t cur;
   int   checks   = 0;
   int   failures = 0;

   logic [31:0] a_digits;
   logic [31:0] b_digits;
   logic [31:0] got_digits;
   logic [31:0] want_digits;
   logic [1:0]  got_flags;

   assign a_digits = {a_if.display7, a_if.display6, a_if.display5, a_if.display4,
                      a_if.display3, a_if.display2, a_if.display1, a_if.display0};
   assign b_digits = {b_if.display7, b_if.display6, b_if.display5, b_if.display4,
                      b_if.display3, b_if.display2, b_if.display1, b_if.display0};

   task automatic want(input string name, input int delay, input bit sel,
                       input logic [15:0] score, input logic [7:0] timer,
                       input logic run, input logic over);
      exp_t e;
      e.name  = name;
      e.due   = cyc + delay;
      e.sel   = sel;
      e.score = score;
      e.timer = timer;
      e.run   = run;
      e.over  = over;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      checks++;
      if ((a_if.running === 1'b1 && a_if.game_over === 1'b1) ||
          (b_if.running === 1'b1 && b_if.game_over === 1'b1)) begin
         failures++;
         $display("FAIL flags_exclusive cycle %0d got running&game_over=1 want 0", cyc);
      end
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         cur         = exp_q.pop_front();
         want_digits = {cur.score, 8'hFF, cur.timer};
         got_digits  = cur.sel ? b_digits : a_digits;
         got_flags   = cur.sel ? {b_if.running, b_if.game_over} : {a_if.running, a_if.game_over};
         checks++;
         if (got_digits !== want_digits) begin
            failures++;
            $display("FAIL %s digits got %h want %h", cur.name, got_digits, want_digits);
         end
         checks++;
         if (got_flags !== {cur.run, cur.over}) begin
            failures++;
            $display("FAIL %s running/game_over got %b want %b", cur.name, got_flags,
                     {cur.run, cur.over});
         end
         $display("txn %-18s cycle=%0d dut=%0d digits=%h flags=%b", cur.name, cyc,
                  cur.sel, got_digits, got_flags);
      end
      if (done) begin
         checks++;
         if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations got %0d want 0", exp_q.size());
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      a_if.start = 1'b0; a_if.hit = 1'b0; a_if.miss = 1'b0;
      b_if.start = 1'b0; b_if.hit = 1'b0; b_if.miss = 1'b0;

      // Reset and idle behaviour
      step(2);
      rst_n = 1'b1;
      want("reset_a", 1, 1'b0, 16'h0000, 8'h03, 1'b0, 1'b0);
      want("reset_b", 1, 1'b1, 16'h0000, 8'h99, 1'b0, 1'b0);
      step(1);
      a_if.hit = 1'b1;
      want("idle_hit_ignored", 1, 1'b0, 16'h0000, 8'h03, 1'b0, 1'b0);
      step(1);
      a_if.hit = 1'b0;

      // Full game on the fast instance
      a_if.start = 1'b1;
      want("start_run",   1, 1'b0, 16'h0000, 8'h03, 1'b1, 1'b0);
      want("pre_tick1",   4, 1'b0, 16'h0000, 8'h03, 1'b1, 1'b0);
      want("tick1",       5, 1'b0, 16'h0000, 8'h02, 1'b1, 1'b0);
      want("tick2",       9, 1'b0, 16'h0000, 8'h01, 1'b1, 1'b0);
      want("pre_final",  12, 1'b0, 16'h0000, 8'h01, 1'b1, 1'b0);
      want("game_over",  13, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1);
      step(1);
      a_if.start = 1'b0;
      step(12);

      // Final-tick corner, restarting from OVER
      a_if.start = 1'b1;
      want("restart",       1, 1'b0, 16'h0000, 8'h03, 1'b1, 1'b0);
      want("before_final", 12, 1'b0, 16'h0000, 8'h01, 1'b1, 1'b0);
      step(1);
      a_if.start = 1'b0;
      step(11);
      a_if.hit = 1'b1;
      want("final_tick_hit",   1, 1'b0, 16'h0001, 8'h00, 1'b0, 1'b1);
      want("late_hit_ignored", 2, 1'b0, 16'h0001, 8'h00, 1'b0, 1'b1);
      step(2);
      a_if.hit = 1'b0;
      a_if.start = 1'b1;
      want("start_from_over", 1, 1'b0, 16'h0000, 8'h03, 1'b1, 1'b0);
      step(1);
      a_if.start = 1'b0;

      // Start ignored in RUN, then reset mid-game
      a_if.hit = 1'b1;
      want("five_hits", 5, 1'b0, 16'h0005, 8'h02, 1'b1, 1'b0);
      step(5);
      a_if.hit = 1'b0;
      a_if.start = 1'b1;
      want("start_in_run", 1, 1'b0, 16'h0005, 8'h02, 1'b1, 1'b0);
      step(1);
      a_if.start = 1'b0;
      rst_n = 1'b0;
      want("reset_midgame", 1, 1'b0, 16'h0000, 8'h03, 1'b0, 1'b0);
      step(1);
      rst_n = 1'b1;
      a_if.hit = 1'b1;
      want("idle_after_reset", 1, 1'b0, 16'h0000, 8'h03, 1'b0, 1'b0);
      step(1);
      a_if.hit = 1'b0;

      // Scoring, carry and saturation on the long-game instance
      b_if.start = 1'b1;
      want("b_start", 1, 1'b1, 16'h0000, 8'h99, 1'b1, 1'b0);
      step(1);
      b_if.start = 1'b0;
      b_if.hit = 1'b1;
      want("b_hit12", 12, 1'b1, 16'h0012, 8'h99, 1'b1, 1'b0);
      step(12);
      b_if.hit = 1'b0; b_if.miss = 1'b1;
      want("b_miss3", 3, 1'b1, 16'h0009, 8'h99, 1'b1, 1'b0);
      step(3);
      b_if.hit = 1'b1;
      want("b_hit_and_miss", 1, 1'b1, 16'h0009, 8'h99, 1'b1, 1'b0);
      step(1);
      b_if.hit = 1'b0;
      want("b_miss_floor", 10, 1'b1, 16'h0000, 8'h99, 1'b1, 1'b0);
      step(10);
      b_if.miss = 1'b0; b_if.hit = 1'b1;
      want("b_to_0999",         999, 1'b1, 16'h0999, 8'h99, 1'b1, 1'b0);
      want("b_carry_1000",     1000, 1'b1, 16'h1000, 8'h99, 1'b1, 1'b0);
      want("b_to_9999",        9999, 1'b1, 16'h9999, 8'h99, 1'b1, 1'b0);
      want("b_saturate",      10000, 1'b1, 16'h9999, 8'h99, 1'b1, 1'b0);
      want("b_saturate_hold", 10005, 1'b1, 16'h9999, 8'h99, 1'b1, 1'b0);
      step(10005);
      b_if.hit = 1'b0;

      step(3);
      done = 1'b1;
      step(5);
      $display("FAIL monitor_finish got running want finished");
      $fatal(1, "monitor did not finish");
   end

endmodule

// File: doc/game_scoreboard.md
# game_scoreboard

Game-level score and countdown engine for whack-a-mole; the stage directly upstream of the 8-digit seven-segment driver. It holds a 4-digit BCD score and a 2-digit BCD seconds countdown, runs an IDLE/RUN/OVER game state machine, and presents eight BCD digit outputs that wire one-to-one onto the driver's `display7`..`display0` inputs. Blank positions carry code 4'hF, which the driver renders as all segments off.

## Interface
- `CLK_HZ`, default 100_000_000: clk cycles per game second; legal range ≥ 2.
- `GAME_SECONDS`, default 60: countdown start value; legal range 1..99, with an elaboration-time check.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle pulse; begins a game from IDLE or OVER.
- `hit`  in  1  single-cycle pulse; mole hit, score +1.
- `miss`  in  1  single-cycle pulse; wrong hole, score −1.
- `running`  out  1  high in RUN.
- `game_over`  out  1  high in OVER.
- `display7`..`display4`  out  4 each  score: thousands, hundreds, tens, units (BCD).
- `display3`, `display2`  out  4 each  constant 4'hF (blank).
- `display1`, `display0`  out  4 each  seconds remaining: tens, units (BCD).

## Operation
- All state is updated on posedge `clk`. When `rst_n` is low at an edge, every register takes its reset value. This applies mid-game as well.
- Reset values:
  - state IDLE; `running`=0, `game_over`=0.
  - score 0000.
  - timer = GAME_SECONDS in BCD (60 → 6,0).
  - prescaler 0.
- **IDLE:** score and timer are held. `hit` and `miss` are ignored. `start` → RUN; score is set to 0000, timer is reloaded, and the prescaler is cleared.
- **RUN:**
  - The prescaler counts 0..CLK_HZ−1. The wrap cycle (count==CLK_HZ−1) is the tick.
  - On a tick, the timer decrements in BCD (units borrow: 0 → 9 with tens −1).
  - If the timer is 01 when a tick occurs, it becomes 00 and the state moves to OVER on the same edge.
  - `hit` only: score +1 in BCD with carry ripple; saturates at 9999.
  - `miss` only: score −1 with borrow; saturates at 0000.
  - `hit` and `miss` together: score unchanged.
  - A `hit` or `miss` in the same cycle as the final tick is applied, because the state is still RUN in that cycle.
  - `start` is ignored.
- **OVER:** score and timer (00) are held. `hit` and `miss` are ignored. `start` → RUN with the same reload as from IDLE.
- Score and timer digits are always valid BCD (0..9); 4'hA..4'hE never appear on any output.

## Timing
- All outputs are registered, or are decoded from registered state with no input-to-output combinational path.
- Input to output latency is 1 cycle. A pulse sampled at edge N is visible on the digits after edge N.
- After `start` is accepted at edge S:
  - The first tick (timer decrement) occurs at edge S+CLK_HZ.
  - OVER is entered at edge S+GAME_SECONDS·CLK_HZ.
- `running` and `game_over` change on the same edge as the state. They are never both high.
- Pulses longer than one cycle count once per cycle high. Edge detection is the producer's responsibility.

## Structure
- **Shared package `game_pkg`:**
  - state enum (IDLE=2'd0, RUN=2'd1, OVER=2'd2).
  - `BLANK_DIGIT` = 4'hF.
  - BCD digit typedef (4 bits).
  - These are also used by the mole generator and the display wiring.
- **Sub-module `bcd_digit`:**
  - One decimal digit with `inc`/`dec` inputs and `carry`/`borrow` outputs.
  - Synchronous active-low clear and load.
  - Instantiated 4× for the score and 2× for the timer.
  - Saturation logic lives in the parent, so the cascade never wraps at the ends.
- The prescaler, FSM and output mapping live in the top level.

## Test plan
All scenarios use `CLK_HZ`=4, `GAME_SECONDS`=3.
1. **Reset:** hold `rst_n`=0 for 2 cycles, release → digits 0,0,0,0,F,F,0,3; `running`=0; `game_over`=0. Pulse `hit` in IDLE → score stays 0000.
2. **Full game:** pulse `start` → `running`=1 next cycle. Timer reads 03 → 02 → 01 → 00 at +4, +8, +12 cycles. At +12, `game_over`=1 and `running`=0.
3. **Scoring:**
   - 12 `hit` pulses → score 0012.
   - 3 `miss` pulses → 0009.
   - `hit` and `miss` together → 0009.
   - `miss` ×10 → 0000 (no underflow).
4. **Carry and saturation:**
   - Force score 0999 via 999 hits with `GAME_SECONDS`=99 and `CLK_HZ` large; next `hit` → 1000.
   - Repeat to 9999; next `hit` → stays 9999.
5. **Final-tick corner:**
   - `hit` in the cycle of the final tick → counted, state OVER.
   - `hit` one cycle later → ignored.
   - `start` in OVER → score 0000, timer 03, RUN.
6. **Reset mid-game:** drop `rst_n` at timer 02 with score 0005 → after the edge, IDLE, 0000, 03. `start` during RUN → no reload.
